// File: rtl/ar_read_arbiter_pkg.sv
// Shared types and constants for the two-master AXI read-address arbiter.
package ar_read_arbiter_pkg;

  localparam int unsigned LenW   = 4;
  localparam int unsigned SizeW  = 2;
  localparam int unsigned BurstW = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } ar_state_e;

  typedef struct packed {
    logic [LenW-1:0]   len;
    logic [SizeW-1:0]  size;
    logic [BurstW-1:0] burst;
  } ar_ctrl_t;

  // The master index occupies the top bit of the slave-side ID.
  function automatic int unsigned master_bit_pos(input int unsigned tag_bits);
    return tag_bits - 1;
  endfunction

endpackage

// File: rtl/ar_read_arbiter_outstanding_counter.sv
// Per-master count of issued read bursts still awaiting their RLAST beat.
module outstanding_counter #(
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic inc,
  input  logic dec,
  output logic at_limit
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [CntW-1:0] count_q;

  // Simultaneous inc/dec cancel; both directions saturate.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      count_q <= '0;
    end else if (inc && !dec && (count_q < CntW'(MaxOutstanding))) begin
      count_q <= count_q + CntW'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_q <= count_q - CntW'(1);
    end
  end

  assign at_limit = (count_q >= CntW'(MaxOutstanding));

endmodule

// File: rtl/ar_read_arbiter.sv
// Round-robin arbiter merging two AXI read masters onto one slave, with
// per-master outstanding-burst limiting and ID-based R-channel routing.
module ar_read_arbiter
  import ar_read_arbiter_pkg::*;
#(
  parameter int unsigned BusWidth       = 32,
  parameter int unsigned tagbits        = 2,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                M0_ARVALID,
  output logic                M0_ARREADY,
  input  logic                M0_ARID,
  input  logic [BusWidth-1:0] M0_ARADDR,
  input  logic [LenW-1:0]     M0_ARLEN,
  input  logic [SizeW-1:0]    M0_ARSIZE,
  input  logic [BurstW-1:0]   M0_ARBURST,
  input  logic                M1_ARVALID,
  output logic                M1_ARREADY,
  input  logic                M1_ARID,
  input  logic [BusWidth-1:0] M1_ARADDR,
  input  logic [LenW-1:0]     M1_ARLEN,
  input  logic [SizeW-1:0]    M1_ARSIZE,
  input  logic [BurstW-1:0]   M1_ARBURST,
  output logic                S_ARVALID,
  input  logic                S_ARREADY,
  output logic [tagbits-1:0]  S_ARID,
  output logic [BusWidth-1:0] S_ARADDR,
  output logic [LenW-1:0]     S_ARLEN,
  output logic [SizeW-1:0]    S_ARSIZE,
  output logic [BurstW-1:0]   S_ARBURST,
  input  logic                S_RVALID,
  input  logic                S_RLAST,
  input  logic [tagbits-1:0]  S_RID,
  input  logic [BusWidth-1:0] S_RDATA,
  input  logic [1:0]          S_RRESP,
  output logic                S_RREADY,
  output logic                M0_RVALID,
  output logic                M0_RLAST,
  output logic                M0_RID,
  output logic [BusWidth-1:0] M0_RDATA,
  output logic [1:0]          M0_RRESP,
  input  logic                M0_RREADY,
  output logic                M1_RVALID,
  output logic                M1_RLAST,
  output logic                M1_RID,
  output logic [BusWidth-1:0] M1_RDATA,
  output logic [1:0]          M1_RRESP,
  input  logic                M1_RREADY
);

  localparam int unsigned MBit = master_bit_pos(tagbits);

  ar_state_e             state_q, state_d;
  logic                  last_grant_q;
  logic [BusWidth-1:0]   addr_q;
  ar_ctrl_t              ctrl_q;
  logic [tagbits-1:0]    id_q, id_d;
  logic                  at_limit0, at_limit1;
  logic                  elig0_c, elig1_c, grant0_c, grant1_c;
  logic                  issue_done_c, r_sel_c, r_last_hs_c;

  assign elig0_c      = M0_ARVALID && !at_limit0;
  assign elig1_c      = M1_ARVALID && !at_limit1;
  assign grant0_c     = elig0_c && (!elig1_c || last_grant_q);
  assign grant1_c     = elig1_c && (!elig0_c || !last_grant_q);
  assign issue_done_c = (state_q == ST_ISSUE) && S_ARREADY;

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant0_c || grant1_c) state_d = ST_ISSUE;
      ST_ISSUE: if (S_ARREADY)            state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    M0_ARREADY = 1'b0;
    M1_ARREADY = 1'b0;
    S_ARVALID  = 1'b0;
    if (!ARESET) begin
      if (state_q == ST_IDLE) begin
        M0_ARREADY = grant0_c;
        M1_ARREADY = grant1_c;
      end
      S_ARVALID = (state_q == ST_ISSUE);
    end
  end

  always_comb begin
    id_d       = '0;
    id_d[MBit] = grant1_c;
    id_d[0]    = grant1_c ? M1_ARID : M0_ARID;
  end

  // Captured address-channel fields, held until the slave accepts them.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr_q       <= '0;
      ctrl_q       <= '0;
      id_q         <= '0;
      last_grant_q <= 1'b1;
    end else begin
      if ((state_q == ST_IDLE) && (grant0_c || grant1_c)) begin
        addr_q <= grant1_c ? M1_ARADDR : M0_ARADDR;
        ctrl_q <= grant1_c ? ar_ctrl_t'({M1_ARLEN, M1_ARSIZE, M1_ARBURST})
                           : ar_ctrl_t'({M0_ARLEN, M0_ARSIZE, M0_ARBURST});
        id_q   <= id_d;
      end
      if (issue_done_c) last_grant_q <= id_q[MBit];
    end
  end

  assign S_ARID    = id_q;
  assign S_ARADDR  = addr_q;
  assign S_ARLEN   = ctrl_q.len;
  assign S_ARSIZE  = ctrl_q.size;
  assign S_ARBURST = ctrl_q.burst;

  // R channel steered by the master bit of the returning ID.
  assign r_sel_c     = S_RID[MBit];
  assign M0_RVALID   = S_RVALID && !r_sel_c;
  assign M1_RVALID   = S_RVALID && r_sel_c;
  assign M0_RID      = S_RID[0];
  assign M1_RID      = S_RID[0];
  assign M0_RDATA    = S_RDATA;
  assign M1_RDATA    = S_RDATA;
  assign M0_RRESP    = S_RRESP;
  assign M1_RRESP    = S_RRESP;
  assign M0_RLAST    = S_RLAST;
  assign M1_RLAST    = S_RLAST;
  assign S_RREADY    = r_sel_c ? M1_RREADY : M0_RREADY;
  assign r_last_hs_c = S_RVALID && S_RREADY && S_RLAST;

  outstanding_counter #(.MaxOutstanding(MaxOutstanding)) u_cnt0 (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .inc      (issue_done_c && !id_q[MBit]),
    .dec      (r_last_hs_c && !r_sel_c),
    .at_limit (at_limit0)
  );

  outstanding_counter #(.MaxOutstanding(MaxOutstanding)) u_cnt1 (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .inc      (issue_done_c && id_q[MBit]),
    .dec      (r_last_hs_c && r_sel_c),
    .at_limit (at_limit1)
  );

endmodule

// File: tb/tb_ar_read_arbiter.sv
// Directed testbench for ar_read_arbiter: arbitration, backpressure, limits,
// R routing and reset behaviour.
module tb_ar_read_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        M0_ARVALID, M0_ARREADY, M0_ARID;
  logic [31:0] M0_ARADDR;
  logic [3:0]  M0_ARLEN;
  logic [1:0]  M0_ARSIZE, M0_ARBURST;
  logic        M1_ARVALID, M1_ARREADY, M1_ARID;
  logic [31:0] M1_ARADDR;
  logic [3:0]  M1_ARLEN;
  logic [1:0]  M1_ARSIZE, M1_ARBURST;
  logic        S_ARVALID, S_ARREADY;
  logic [1:0]  S_ARID;
  logic [31:0] S_ARADDR;
  logic [3:0]  S_ARLEN;
  logic [1:0]  S_ARSIZE, S_ARBURST;
  logic        S_RVALID, S_RLAST, S_RREADY;
  logic [1:0]  S_RID;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        M0_RVALID, M0_RLAST, M0_RID, M0_RREADY;
  logic [31:0] M0_RDATA;
  logic [1:0]  M0_RRESP;
  logic        M1_RVALID, M1_RLAST, M1_RID, M1_RREADY;
  logic [31:0] M1_RDATA;
  logic [1:0]  M1_RRESP;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  ar_read_arbiter dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY), .M0_ARID(M0_ARID),
    .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_ARSIZE(M0_ARSIZE), .M0_ARBURST(M0_ARBURST),
    .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY), .M1_ARID(M1_ARID),
    .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN), .M1_ARSIZE(M1_ARSIZE), .M1_ARBURST(M1_ARBURST),
    .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY), .S_ARID(S_ARID), .S_ARADDR(S_ARADDR),
    .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
    .S_RVALID(S_RVALID), .S_RLAST(S_RLAST), .S_RID(S_RID), .S_RDATA(S_RDATA),
    .S_RRESP(S_RRESP), .S_RREADY(S_RREADY),
    .M0_RVALID(M0_RVALID), .M0_RLAST(M0_RLAST), .M0_RID(M0_RID), .M0_RDATA(M0_RDATA),
    .M0_RRESP(M0_RRESP), .M0_RREADY(M0_RREADY),
    .M1_RVALID(M1_RVALID), .M1_RLAST(M1_RLAST), .M1_RID(M1_RID), .M1_RDATA(M1_RDATA),
    .M1_RRESP(M1_RRESP), .M1_RREADY(M1_RREADY)
  );

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    M0_ARVALID = 0; M0_ARID = 0; M0_ARADDR = '0; M0_ARLEN = '0; M0_ARSIZE = '0; M0_ARBURST = '0;
    M1_ARVALID = 0; M1_ARID = 0; M1_ARADDR = '0; M1_ARLEN = '0; M1_ARSIZE = '0; M1_ARBURST = '0;
    S_ARREADY = 0; S_RVALID = 0; S_RLAST = 0; S_RID = '0; S_RDATA = '0; S_RRESP = '0;
    M0_RREADY = 0; M1_RREADY = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ARESET = 1;
    cyc();
    cyc();
    ARESET = 0;
  endtask

  // One RLAST beat on the R channel with both masters ready.
  task automatic r_last_beat(input logic [1:0] id);
    S_RVALID = 1; S_RLAST = 1; S_RID = id; M0_RREADY = 1; M1_RREADY = 1;
    cyc();
    S_RVALID = 0; S_RLAST = 0; M0_RREADY = 0; M1_RREADY = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    ARESET = 1;
    M0_ARVALID = 1; M1_ARVALID = 1;
    cyc();
    #1;
    total++; if (M0_ARREADY !== 1'b0) begin bad++; $display("FAIL rst_m0_arready got=%0b want=0", M0_ARREADY); end
    total++; if (M1_ARREADY !== 1'b0) begin bad++; $display("FAIL rst_m1_arready got=%0b want=0", M1_ARREADY); end
    total++; if (S_ARVALID !== 1'b0) begin bad++; $display("FAIL rst_s_arvalid got=%0b want=0", S_ARVALID); end
    total++; if ({S_ARID, S_ARADDR} !== 34'h0) begin bad++; $display("FAIL rst_s_ar_fields got=%h want=0", {S_ARID, S_ARADDR}); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    M0_ARVALID = 1; M0_ARID = 1; M0_ARADDR = 32'h100; M0_ARLEN = 4'd3;
    #1;
    total++; if (M0_ARREADY !== 1'b1) begin bad++; $display("FAIL single_m0_arready got=%0b want=1", M0_ARREADY); end
    total++; if (S_ARVALID !== 1'b0) begin bad++; $display("FAIL single_s_arvalid_early got=%0b want=0", S_ARVALID); end
    cyc();
    M0_ARVALID = 0; S_ARREADY = 1;
    #1;
    total++; if (S_ARVALID !== 1'b1) begin bad++; $display("FAIL single_s_arvalid got=%0b want=1", S_ARVALID); end
    total++; if (S_ARID !== 2'b01) begin bad++; $display("FAIL single_s_arid got=%b want=01", S_ARID); end
    total++; if (S_ARADDR !== 32'h100) begin bad++; $display("FAIL single_s_araddr got=%h want=00000100", S_ARADDR); end
    total++; if (S_ARLEN !== 4'd3) begin bad++; $display("FAIL single_s_arlen got=%0d want=3", S_ARLEN); end
    cyc();
    S_ARREADY = 0;
    #1;
    total++; if (S_ARVALID !== 1'b0) begin bad++; $display("FAIL single_s_arvalid_done got=%0b want=0", S_ARVALID); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_seq;
    do_reset();
    M0_ARVALID = 1; M0_ARADDR = 32'hA0; M1_ARVALID = 1; M1_ARADDR = 32'hB0; M1_ARID = 1;
    S_ARREADY = 1;
    for (int i = 0; i < 4; i++) begin
      exp_seq = 2'(i % 2);
      #1;
      total++; if ({M1_ARREADY, M0_ARREADY} !== (exp_seq[0] ? 2'b10 : 2'b01)) begin bad++; $display("FAIL contention_ready[%0d] got=%b want=%b", i, {M1_ARREADY, M0_ARREADY}, (exp_seq[0] ? 2'b10 : 2'b01)); end
      cyc();
      total++; if (S_ARID[1] !== exp_seq[0]) begin bad++; $display("FAIL contention_master[%0d] got=%0b want=%0b", i, S_ARID[1], exp_seq[0]); end
      total++; if (S_ARADDR !== (exp_seq[0] ? 32'hB0 : 32'hA0)) begin bad++; $display("FAIL contention_addr[%0d] got=%h want=%h", i, S_ARADDR, (exp_seq[0] ? 32'hB0 : 32'hA0)); end
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    M1_ARVALID = 1; M1_ARID = 0; M1_ARADDR = 32'h200; M1_ARLEN = 4'd7; M1_ARSIZE = 2'd2; M1_ARBURST = 2'd1;
    #1;
    total++; if (M1_ARREADY !== 1'b1) begin bad++; $display("FAIL bp_m1_arready got=%0b want=1", M1_ARREADY); end
    cyc();
    M1_ARVALID = 0; M1_ARADDR = 32'hFFFF; M0_ARVALID = 1; M0_ARADDR = 32'h300;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if ({S_ARVALID, S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST} !== {1'b1, 2'b10, 32'h200, 4'd7, 2'd2, 2'd1})
        begin bad++; $display("FAIL bp_hold[%0d] got=%b/%b/%h/%0d/%0d/%0d want=1/10/00000200/7/2/1", i, S_ARVALID, S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST); end
      total++; if ({M0_ARREADY, M1_ARREADY} !== 2'b00) begin bad++; $display("FAIL bp_arready[%0d] got=%b want=00", i, {M0_ARREADY, M1_ARREADY}); end
      cyc();
    end
    S_ARREADY = 1;
    #1;
    total++; if (S_ARVALID !== 1'b1) begin bad++; $display("FAIL bp_sixth_valid got=%0b want=1", S_ARVALID); end
    cyc();
    S_ARREADY = 0;
    #1;
    total++; if (S_ARVALID !== 1'b0) begin bad++; $display("FAIL bp_done_valid got=%0b want=0", S_ARVALID); end
    total++; if (M0_ARREADY !== 1'b1) begin bad++; $display("FAIL bp_m0_after got=%0b want=1", M0_ARREADY); end
    idle_inputs();
  endtask

  task automatic test_limit();
    do_reset();
    r_last_beat(2'b00);
    M0_ARVALID = 1; S_ARREADY = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (M0_ARREADY !== 1'b1) begin bad++; $display("FAIL limit_fill[%0d] got=%0b want=1", i, M0_ARREADY); end
      cyc();
      cyc();
    end
    M1_ARVALID = 1; M1_ARID = 1;
    #1;
    total++; if ({M0_ARREADY, M1_ARREADY} !== 2'b01) begin bad++; $display("FAIL limit_skip got=%b want=01", {M0_ARREADY, M1_ARREADY}); end
    cyc();
    total++; if (S_ARID !== 2'b11) begin bad++; $display("FAIL limit_m1_id got=%b want=11", S_ARID); end
    cyc();
    M1_ARVALID = 0;
    S_RVALID = 1; S_RLAST = 0; S_RID = 2'b00; M0_RREADY = 1;
    cyc();
    S_RLAST = 1; S_RID = 2'b10; M1_RREADY = 1;
    cyc();
    S_RVALID = 0; S_RLAST = 0; M0_RREADY = 0; M1_RREADY = 0;
    #1;
    total++; if (M0_ARREADY !== 1'b0) begin bad++; $display("FAIL limit_still_blocked got=%0b want=0", M0_ARREADY); end
    r_last_beat(2'b00);
    #1;
    total++; if (M0_ARREADY !== 1'b1) begin bad++; $display("FAIL limit_freed got=%0b want=1", M0_ARREADY); end
    cyc();
    S_RVALID = 1; S_RLAST = 1; S_RID = 2'b00; M0_RREADY = 1;
    cyc();
    S_RVALID = 0; S_RLAST = 0; M0_RREADY = 0;
    #1;
    total++; if (M0_ARREADY !== 1'b1) begin bad++; $display("FAIL limit_inc_dec_same got=%0b want=1", M0_ARREADY); end
    cyc();
    cyc();
    #1;
    total++; if (M0_ARREADY !== 1'b0) begin bad++; $display("FAIL limit_refilled got=%0b want=0", M0_ARREADY); end
    idle_inputs();
  endtask

  task automatic test_r_routing();
    idle_inputs();
    S_RVALID = 1; S_RID = 2'b11; S_RDATA = 32'hDEADBEEF; S_RRESP = 2'b10; M1_RREADY = 1; M0_RREADY = 0;
    #1;
    total++; if ({M1_RVALID, M1_RID, M0_RVALID, S_RREADY} !== 4'b1101) begin bad++; $display("FAIL route_m1 got=%b want=1101", {M1_RVALID, M1_RID, M0_RVALID, S_RREADY}); end
    total++; if ({M0_RDATA, M1_RDATA, M0_RRESP, M1_RRESP} !== {32'hDEADBEEF, 32'hDEADBEEF, 2'b10, 2'b10}) begin bad++; $display("FAIL route_fanout got=%h/%h/%b/%b want=deadbeef/deadbeef/10/10", M0_RDATA, M1_RDATA, M0_RRESP, M1_RRESP); end
    S_RID = 2'b01; S_RDATA = 32'h12345678;
    #1;
    total++; if ({M0_RVALID, M0_RID, M1_RVALID, S_RREADY} !== 4'b1100) begin bad++; $display("FAIL route_m0 got=%b want=1100", {M0_RVALID, M0_RID, M1_RVALID, S_RREADY}); end
    total++; if (M0_RDATA !== 32'h12345678) begin bad++; $display("FAIL route_m0_data got=%h want=12345678", M0_RDATA); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    M0_ARVALID = 1; S_ARREADY = 1;
    cyc();
    cyc();
    M0_ARVALID = 0; S_ARREADY = 0; M1_ARVALID = 1; M1_ARADDR = 32'h400;
    cyc();
    #1;
    total++; if (S_ARVALID !== 1'b1) begin bad++; $display("FAIL rmid_in_issue got=%0b want=1", S_ARVALID); end
    ARESET = 1; M0_ARVALID = 1;
    cyc();
    #1;
    total++; if (S_ARVALID !== 1'b0) begin bad++; $display("FAIL rmid_s_arvalid got=%0b want=0", S_ARVALID); end
    total++; if ({S_ARID, S_ARADDR} !== 34'h0) begin bad++; $display("FAIL rmid_fields got=%h want=0", {S_ARID, S_ARADDR}); end
    total++; if ({M0_ARREADY, M1_ARREADY} !== 2'b00) begin bad++; $display("FAIL rmid_arready got=%b want=00", {M0_ARREADY, M1_ARREADY}); end
    ARESET = 0;
    #1;
    total++; if ({M0_ARREADY, M1_ARREADY} !== 2'b10) begin bad++; $display("FAIL rmid_first_grant got=%b want=10", {M0_ARREADY, M1_ARREADY}); end
    M1_ARVALID = 0; S_ARREADY = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (M0_ARREADY !== 1'b1) begin bad++; $display("FAIL rmid_count_clear[%0d] got=%0b want=1", i, M0_ARREADY); end
      cyc();
      cyc();
    end
    #1;
    total++; if (M0_ARREADY !== 1'b0) begin bad++; $display("FAIL rmid_limit got=%0b want=0", M0_ARREADY); end
    idle_inputs();
  endtask

  initial begin
    ARESET = 1;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_limit();
    test_r_routing();
    test_reset_mid_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
